// File: rtl/fft_sched_pkg.sv
// Shared types and constants for the two-requester FFT frame scheduler.
package fft_sched_pkg;
  localparam int FRAME_LEN = 64;
  localparam int ADDR_W    = 6;
  localparam int DATA_W    = 32;

  localparam logic MODE_FWD = 1'b0;
  localparam logic MODE_INV = 1'b1;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_LEN - 1);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_WAIT_OUT = 3'd2,
    ST_DRAIN    = 3'd3,
    ST_DONE     = 3'd4
  } sched_state_t;
endpackage

// File: rtl/fft_rr_arbiter.sv
// Two-way round-robin arbiter: a lone requester wins, a tie goes to ptr.
module fft_rr_arbiter (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] winner
);
  always_comb begin
    winner = 2'b00;
    case (req)
      2'b01:   winner = 2'b01;
      2'b10:   winner = 2'b10;
      2'b11:   winner = ptr ? 2'b10 : 2'b01;
      default: winner = 2'b00;
    endcase
  end
endmodule

// File: rtl/fft_frame_scheduler.sv
// Shares one 64-point FFT core between two requesters: grant, stream the frame
// in, capture the 64-word result burst, write it back and pulse done.
module fft_frame_scheduler
  import fft_sched_pkg::*;
#(
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req,
  input  logic [1:0]        req_mode,
  output logic [1:0]        gnt,
  output logic [1:0]        rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data0,
  input  logic [DATA_W-1:0] rd_data1,
  output logic [1:0]        wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [1:0]        done,
  output logic              err_timeout,
  output logic              busy,
  output logic [DATA_W-1:0] core_in_stream,
  output logic              core_mode,
  output logic              core_data_start,
  input  logic [DATA_W-1:0] core_out_stream,
  input  logic              core_data_out,
  output logic [2:0]        dbg_state
);
  localparam int WD_W = $clog2(TIMEOUT + 1);

  // Requester handshake: req is a level held until done; gnt is held from the
  // grant edge until done; done is a one-cycle pulse to the served requester.
  sched_state_t      state, state_d;
  logic              rr_ptr, rr_d;
  logic [ADDR_W-1:0] cnt, cnt_d;
  logic [WD_W-1:0]   wd, wd_d;
  logic              rd_v, rd_v_d;
  logic [1:0]        gnt_d, rd_en_d, wr_en_d, done_d, winner, eligible;
  logic [ADDR_W-1:0] rd_addr_d, wr_addr_d;
  logic [DATA_W-1:0] wr_data_d, in_d;
  logic              mode_d, start_d, err_d, busy_d;

  // A requester still holding req during its own done cycle is not re-granted.
  assign eligible  = req & ~done;
  assign dbg_state = state;

  fft_rr_arbiter u_arb (
    .req    (eligible),
    .ptr    (rr_ptr),
    .winner (winner)
  );

  always_comb begin
    state_d   = state;
    gnt_d     = gnt;
    mode_d    = core_mode;
    rr_d      = rr_ptr;
    cnt_d     = cnt;
    wd_d      = wd;
    rd_en_d   = rd_en;
    rd_addr_d = rd_addr;
    rd_v_d    = |rd_en;
    start_d   = rd_v;
    in_d      = rd_v ? (gnt[1] ? rd_data1 : rd_data0) : '0;
    wr_en_d   = 2'b00;
    wr_addr_d = wr_addr;
    wr_data_d = wr_data;
    done_d    = 2'b00;
    err_d     = err_timeout;
    case (state)
      ST_IDLE: begin
        if (|winner) begin
          gnt_d     = winner;
          mode_d    = |(req_mode & winner);
          rd_en_d   = winner;
          rd_addr_d = '0;
          cnt_d     = '0;
          state_d   = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (|rd_en) begin
          if (rd_addr == LAST_IDX) begin
            rd_en_d   = 2'b00;
            rd_addr_d = '0;
          end else begin
            rd_addr_d = rd_addr + ADDR_W'(1);
          end
        end
        // cnt tracks samples already handed to the core, two cycles behind rd_addr.
        if (core_data_start) begin
          cnt_d = cnt + ADDR_W'(1);
          if (cnt == LAST_IDX) begin
            wd_d    = '0;
            state_d = ST_WAIT_OUT;
          end
        end
      end
      ST_WAIT_OUT: begin
        wd_d = wd + WD_W'(1);
        if (core_data_out) begin
          wr_en_d   = gnt;
          wr_addr_d = '0;
          wr_data_d = core_out_stream;
          cnt_d     = ADDR_W'(1);
          state_d   = ST_DRAIN;
        end else if (wd == WD_W'(TIMEOUT - 1)) begin
          // Abort: the requester is released as if served, so the pointer moves too.
          err_d   = 1'b1;
          done_d  = gnt;
          gnt_d   = 2'b00;
          mode_d  = MODE_FWD;
          rr_d    = gnt[0];
          state_d = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        wr_en_d   = gnt;
        wr_addr_d = cnt;
        wr_data_d = core_out_stream;
        cnt_d     = cnt + ADDR_W'(1);
        if (cnt == LAST_IDX) state_d = ST_DONE;
      end
      ST_DONE: begin
        done_d  = gnt;
        gnt_d   = 2'b00;
        mode_d  = MODE_FWD;
        rr_d    = gnt[0];
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_IDLE;
      rr_ptr          <= 1'b0;
      cnt             <= '0;
      wd              <= '0;
      rd_v            <= 1'b0;
      gnt             <= 2'b00;
      rd_en           <= 2'b00;
      rd_addr         <= '0;
      wr_en           <= 2'b00;
      wr_addr         <= '0;
      wr_data         <= '0;
      done            <= 2'b00;
      err_timeout     <= 1'b0;
      busy            <= 1'b0;
      core_in_stream  <= '0;
      core_mode       <= 1'b0;
      core_data_start <= 1'b0;
    end else begin
      state           <= state_d;
      rr_ptr          <= rr_d;
      cnt             <= cnt_d;
      wd              <= wd_d;
      rd_v            <= rd_v_d;
      gnt             <= gnt_d;
      rd_en           <= rd_en_d;
      rd_addr         <= rd_addr_d;
      wr_en           <= wr_en_d;
      wr_addr         <= wr_addr_d;
      wr_data         <= wr_data_d;
      done            <= done_d;
      err_timeout     <= err_d;
      busy            <= busy_d;
      core_in_stream  <= in_d;
      core_mode       <= mode_d;
      core_data_start <= start_d;
    end
  end
endmodule

// File: tb/tb_fft_frame_scheduler.sv
// Directed bench for fft_frame_scheduler with requester buffers and a model
// FFT core that answers CORE_LAT cycles after the last input sample.
module tb_fft_frame_scheduler;
  import fft_sched_pkg::*;

  localparam int TIMEOUT  = 1024;
  localparam int CORE_LAT = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req = 2'b00;
  logic [1:0]  req_mode = 2'b00;
  logic [31:0] rd_data0 = '0;
  logic [31:0] rd_data1 = '0;
  logic [31:0] core_out_stream = '0;
  logic        core_data_out = 1'b0;
  logic [1:0]  gnt, rd_en, wr_en, done;
  logic [5:0]  rd_addr, wr_addr;
  logic [31:0] wr_data, core_in_stream;
  logic        err_timeout, busy, core_mode, core_data_start;
  logic [2:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fft_frame_scheduler #(.TIMEOUT(TIMEOUT)) dut (
    .clk             (clk),
    .rst             (rst),
    .req             (req),
    .req_mode        (req_mode),
    .gnt             (gnt),
    .rd_en           (rd_en),
    .rd_addr         (rd_addr),
    .rd_data0        (rd_data0),
    .rd_data1        (rd_data1),
    .wr_en           (wr_en),
    .wr_addr         (wr_addr),
    .wr_data         (wr_data),
    .done            (done),
    .err_timeout     (err_timeout),
    .busy            (busy),
    .core_in_stream  (core_in_stream),
    .core_mode       (core_mode),
    .core_data_start (core_data_start),
    .core_out_stream (core_out_stream),
    .core_data_out   (core_data_out),
    .dbg_state       (dbg_state)
  );

  // Requester frame buffers with one-cycle read latency.
  logic [31:0] buf0 [64];
  logic [31:0] buf1 [64];

  always @(posedge clk) begin
    if (rd_en[0]) rd_data0 <= buf0[rd_addr];
    if (rd_en[1]) rd_data1 <= buf1[rd_addr];
  end

  function automatic logic [31:0] xform(input logic [31:0] d, input int i, input logic m);
    logic [31:0] r;
    if (m) r = ~d + 32'(i);
    else   r = (d ^ 32'h5A5A_0000) + 32'(i);
    return r;
  endfunction

  function automatic logic [31:0] get_word(input int w, input int i);
    return (w == 1) ? buf1[i] : buf0[i];
  endfunction

  // Model core: collect 64 samples, wait CORE_LAT cycles, emit 64 results.
  logic [31:0] cap_buf [64];
  logic        cap_mode = 1'b0;
  logic        core_silent = 1'b0;
  int          cap_n, emit_n, dly, phase;

  always @(posedge clk) begin
    if (rst) begin
      phase           <= 0;
      cap_n           <= 0;
      emit_n          <= 0;
      dly             <= 0;
      core_data_out   <= 1'b0;
      core_out_stream <= '0;
    end else begin
      case (phase)
        0: if (core_data_start) begin
          cap_buf[cap_n] <= core_in_stream;
          cap_mode       <= core_mode;
          cap_n          <= cap_n + 1;
          if (cap_n == 63) begin
            phase <= 1;
            dly   <= 0;
          end
        end
        1: if (core_silent) begin
          phase <= 0;
          cap_n <= 0;
        end else begin
          dly <= dly + 1;
          if (dly == CORE_LAT - 1) begin
            phase  <= 2;
            emit_n <= 0;
          end
        end
        2: begin
          core_data_out   <= 1'b1;
          core_out_stream <= xform(cap_buf[emit_n], emit_n, cap_mode);
          emit_n          <= emit_n + 1;
          if (emit_n == 63) phase <= 3;
        end
        default: begin
          core_data_out   <= 1'b0;
          core_out_stream <= '0;
          phase           <= 0;
          cap_n           <= 0;
        end
      endcase
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"},     32'(gnt), 32'd0);
    check({tag, "_rd_en"},   32'(rd_en), 32'd0);
    check({tag, "_rd_addr"}, 32'(rd_addr), 32'd0);
    check({tag, "_wr_en"},   32'(wr_en), 32'd0);
    check({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
    check({tag, "_wr_data"}, wr_data, 32'd0);
    check({tag, "_done"},    32'(done), 32'd0);
    check({tag, "_err"},     32'(err_timeout), 32'd0);
    check({tag, "_busy"},    32'(busy), 32'd0);
    check({tag, "_in"},      core_in_stream, 32'd0);
    check({tag, "_mode"},    32'(core_mode), 32'd0);
    check({tag, "_start"},   32'(core_data_start), 32'd0);
    check({tag, "_state"},   32'(dbg_state), 32'd0);
  endtask

  task automatic fill_buffers(input int code);
    for (int i = 0; i < 64; i++) begin
      case (code)
        0: begin
          buf0[i] = 32'(i);
          buf1[i] = 32'h0100_0000 + 32'(i);
        end
        1: begin
          buf0[i] = 32'hDEAD_0000 | 32'(i * 3);
          buf1[i] = 32'hFFFF_FFFF - 32'(i);
        end
        default: begin
          buf0[i] = {16'(i), ~16'(i)};
          buf1[i] = 32'h8000_0001 << (i % 31);
        end
      endcase
    end
  endtask

  // Follows one job from grant to done (or to an abort by reset at abort_at).
  task automatic serve_job(input int w, input logic m, input logic silent, input logic exp_err,
                           input logic drop_in_load, input int abort_at);
    logic [1:0] oh;
    logic       prev_cdo;
    int         t;
    oh = 2'b01 << w;
    core_silent = silent;
    t = 0;
    while (gnt == 2'b00 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("grant_latency", 32'(t), 32'd1);
    check("gnt", 32'(gnt), 32'(oh));
    check("mode_at_grant", 32'(core_mode), 32'(m));
    check("busy_at_grant", 32'(busy), 32'd1);
    for (int c = 0; c < 66; c++) begin
      check("rd_en", 32'(rd_en), (c < 64) ? 32'(oh) : 32'd0);
      if (c < 64) check("rd_addr", 32'(rd_addr), 32'(c));
      check("data_start", 32'(core_data_start), (c >= 2) ? 32'd1 : 32'd0);
      if (c >= 2) check("in_stream", core_in_stream, get_word(w, c - 2));
      else        check("in_stream_idle", core_in_stream, 32'd0);
      check("mode_load", 32'(core_mode), 32'(m));
      if (drop_in_load && c == 10) req[w] = 1'b0;
      @(negedge clk);
    end
    if (silent) begin
      for (int k = 0; k < TIMEOUT; k++) begin
        check("wd_no_write", 32'(wr_en), 32'd0);
        check("wd_no_done", 32'(done), 32'd0);
        check("wd_gnt_held", 32'(gnt), 32'(oh));
        @(negedge clk);
      end
      check("wd_err_set", 32'(err_timeout), 32'd1);
      check("wd_done", 32'(done), 32'(oh));
      check("wd_gnt_drop", 32'(gnt), 32'd0);
      check("wd_no_write_end", 32'(wr_en), 32'd0);
      return;
    end
    t = 0;
    prev_cdo = 1'b0;
    while (wr_en == 2'b00 && t < 300) begin
      prev_cdo = core_data_out;
      @(negedge clk);
      t++;
    end
    check("wr_wait_bound", 32'(t < 300), 32'd1);
    check("wr_after_capture", 32'(prev_cdo), 32'd1);
    for (int i = 0; i < 64; i++) begin
      check("wr_en", 32'(wr_en), 32'(oh));
      check("wr_addr", 32'(wr_addr), 32'(i));
      check("wr_data", wr_data, xform(get_word(w, i), i, m));
      check("mode_drain", 32'(core_mode), 32'(m));
      check("no_early_done", 32'(done), 32'd0);
      if (i == abort_at) begin
        rst = 1'b1;
        req = 2'b00;
        @(negedge clk);
        check_all_zero("reset_mid_drain");
        rst = 1'b0;
        return;
      end
      @(negedge clk);
    end
    check("done_pulse", 32'(done), 32'(oh));
    check("done_wr_off", 32'(wr_en), 32'd0);
    check("done_gnt_drop", 32'(gnt), 32'd0);
    check("done_busy", 32'(busy), 32'd0);
    check("done_err", 32'(err_timeout), 32'(exp_err));
  endtask

  typedef struct {
    logic [1:0] req;
    logic [1:0] mode;
    int         fill;
    int         winner;
    logic       exp_mode;
  } job_vec_t;

  job_vec_t vecs [4];

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: run exceeded time limit");
    $fatal(1, "time limit");
  end

  initial begin
    logic saw_done;
    vecs[0] = '{2'b01, 2'b00, 0, 0, 1'b0};
    vecs[1] = '{2'b10, 2'b10, 1, 1, 1'b1};
    vecs[2] = '{2'b01, 2'b01, 2, 0, 1'b1};
    vecs[3] = '{2'b10, 2'b01, 1, 1, 1'b0};

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    check("idle_after_reset", 32'(busy), 32'd0);

    for (int v = 0; v < 4; v++) begin
      fill_buffers(vecs[v].fill);
      req_mode = vecs[v].mode;
      req      = vecs[v].req;
      serve_job(vecs[v].winner, vecs[v].exp_mode, 1'b0, 1'b0, 1'b0, -1);
      req = 2'b00;
      @(negedge clk);
      check("done_one_cycle", 32'(done), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
    end

    // Contention from reset: requester 0 first, then 1 on the cycle after done.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    fill_buffers(1);
    req_mode = 2'b10;
    req      = 2'b11;
    serve_job(0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    req[0] = 1'b0;
    serve_job(1, 1'b1, 1'b0, 1'b0, 1'b0, -1);
    req = 2'b00;
    @(negedge clk);
    req_mode = 2'b01;
    req      = 2'b11;
    serve_job(0, 1'b1, 1'b0, 1'b0, 1'b0, -1);
    req[0] = 1'b0;
    serve_job(1, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    req = 2'b00;
    @(negedge clk);

    // Watchdog, then a normal job with the sticky error still set.
    fill_buffers(2);
    req_mode = 2'b00;
    req      = 2'b01;
    serve_job(0, 1'b0, 1'b1, 1'b0, 1'b0, -1);
    req = 2'b00;
    @(negedge clk);
    check("err_sticky_idle", 32'(err_timeout), 32'd1);
    check("wd_done_one_cycle", 32'(done), 32'd0);
    req_mode = 2'b10;
    req      = 2'b10;
    serve_job(1, 1'b1, 1'b0, 1'b1, 1'b0, -1);
    req = 2'b00;
    @(negedge clk);

    // Reset at result word 30, then a fresh grant to requester 1.
    fill_buffers(0);
    req_mode = 2'b00;
    req      = 2'b01;
    serve_job(0, 1'b0, 1'b0, 1'b1, 1'b0, 30);
    saw_done = 1'b0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (done != 2'b00 || busy) saw_done = 1'b1;
    end
    check("no_done_after_reset", 32'(saw_done), 32'd0);
    req_mode = 2'b00;
    req      = 2'b10;
    serve_job(1, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    req = 2'b00;
    @(negedge clk);

    // Requester 0 drops req during LOAD; the job still completes.
    fill_buffers(2);
    req_mode = 2'b01;
    req      = 2'b01;
    serve_job(0, 1'b1, 1'b0, 1'b0, 1'b1, -1);
    req = 2'b00;
    @(negedge clk);
    check("final_idle", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/fft_frame_scheduler.md
Name: fft_frame_scheduler

Overview:
- Shares one fft_64p_16b_top core between two frame requesters (e.g. a forward-transform client and an inverse-transform client).
- Per job: arbitrates round-robin, reads the winner's 64-sample frame from its buffer and streams it into the core with Data_Start.
- Holds the requested Mode for the whole frame, captures the 64-word Data_Out burst, writes it back into the winner's result buffer, then signals done.
- Exactly one frame is in flight at a time. A watchdog flags a core that never answers.

Parameters:
- FRAME_LEN, 64, samples per frame; fixed by the core; address width is log2 = 6.
- DATA_W, 32, sample width ({re16, im16}, as on the core's In_Stream/Out_Stream).
- TIMEOUT, 1024, maximum cycles in WAIT_OUT before abort.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- req  in  2  frame request per requester; level, held until done
- req_mode  in  2  transform mode per requester; 0 = forward, 1 = inverse; sampled at grant
- gnt  out  2  one-hot grant, held from grant until done
- rd_en  out  2  buffer read strobe to the granted requester
- rd_addr  out  6  shared read address
- rd_data0  in  32  requester 0 buffer data; valid 1 cycle after rd_en
- rd_data1  in  32  requester 1 buffer data; valid 1 cycle after rd_en
- wr_en  out  2  result write strobe to the granted requester
- wr_addr  out  6  shared result write address
- wr_data  out  32  result word
- done  out  2  1-cycle completion pulse to the granted requester
- err_timeout  out  1  sticky; set on watchdog abort; cleared only by rst
- busy  out  1  high in any state other than IDLE
- core_in_stream  out  32  to core In_Stream
- core_mode  out  1  to core Mode
- core_data_start  out  1  to core Data_Start
- core_out_stream  in  32  from core Out_Stream
- core_data_out  in  1  from core Data_Out

Behaviour:
- Reset:
  - All outputs are registered and go to 0 at the next edge with rst=1.
  - State goes to IDLE; rr pointer goes to 0 (requester 0 has priority first).
  - Reset mid-frame abandons the job; no done is issued.
- States: IDLE, LOAD, WAIT_OUT, DRAIN, DONE.
- IDLE:
  - If any req bit is set, the arbiter picks the winner: a single requester wins outright; on a tie the rr pointer decides.
  - At the edge: gnt and core_mode (= req_mode[winner]) are registered, the frame counter is cleared, and state goes to LOAD.
  - The rr pointer moves to the other requester when the job enters DONE.
- LOAD:
  - rd_en[winner] is high for 64 consecutive cycles, with rd_addr = 0..63.
  - Two-stage feed: rd_addr = i at cycle t; rd_data valid at t+1; at t+2 core_in_stream = sample i and core_data_start = 1.
  - core_data_start is therefore high for exactly 64 contiguous cycles, starting 2 cycles after the first rd_en.
  - State goes to WAIT_OUT after the last sample is issued to the core. core_in_stream returns to 0 when not streaming.
- WAIT_OUT:
  - The watchdog counter increments each cycle.
  - First core_data_out=1 goes to DRAIN, and that cycle's word is captured as index 0.
  - Watchdog reaching TIMEOUT sets err_timeout, pulses done[winner], and returns to IDLE (DONE is skipped).
- DRAIN:
  - Captures 64 consecutive words: wr_en[winner]=1, wr_addr = 0..63, wr_data = core_out_stream, each 1 cycle after capture.
  - The internal counter rules; core_data_out is ignored after the first cycle.
  - After index 63 is written, state goes to DONE.
- DONE:
  - done[winner] is high for 1 cycle; gnt drops the same edge; the rr pointer toggles; state returns to IDLE.
  - A pending other requester is granted on the following cycle.
- core_mode is constant from grant through DONE.
- req deasserting mid-job is ignored; the job completes.
- A req arriving while busy waits; there is no preemption.
- Counters are 6-bit and wrap 63 to 0 by design. The terminal condition is the count reaching 63, not the overflow.

Decomposition:
- Package fft_sched_pkg holds: the state enum, FRAME_LEN, ADDR_W=6, DATA_W, and the MODE_FWD=0 / MODE_INV=1 constants.
- One sub-module: fft_rr_arbiter (2-way round-robin; inputs req, ptr; output one-hot winner; combinational and isolated-testable).

Test Plan:
- Single job: req=2'b01, req_mode=0, buffer 0 = ramp 0x00000000..0x0000003F.
  - rd_en[0] high 64 cycles; core_data_start high 64 cycles beginning 2 cycles later, carrying the ramp in order; core_mode=0 throughout.
  - A model core answering after 20 cycles causes wr_en[0] ×64 with wr_addr 0..63 and data as emitted; done[0] one cycle after the last write.
- Contention: req=2'b11 asserted together from reset.
  - Requester 0 is served first with its mode; gnt=2'b10 on the cycle after done[0]; requester 1 mode=1 drives core_mode=1.
  - Next tie goes to requester 0 again only after requester 1 has been served.
- Watchdog: the model core never raises core_data_out.
  - Exactly TIMEOUT cycles after LOAD ends: err_timeout=1, done pulse issued, no wr_en.
  - A following job still completes normally and err_timeout stays 1.
- Reset mid-DRAIN: rst asserted at output word 30.
  - All outputs are 0 the next cycle; no done; a new req=2'b10 is granted normally after release.
- Mid-job req drop: requester 0 deasserts req during LOAD.
  - The frame still streams all 64 samples, writes 64 results, and pulses done[0].
